branch_resolve_ctrl: RTL
========================

# branch_resolve_ctrl

Sequences branch resolutions into the branch stack. Two branch units can report resolved branches in the same cycle, but the branch stack accepts one resolution per cycle. This block buffers the reports in a tag-indexed pending table and issues the oldest mispredict first, otherwise the lowest-tag correct prediction. After a mispredict it runs a fixed-length recovery window that stalls fetch and dispatch.

## Interface
- N_BS, 4: branch stack entries and pending-table slots; tag width is log2(N_BS)
- RECOVER_CYCLES, 2: cycles of ctrl_recovering after each mispredict issue, ≥1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low; reset==0 at posedge resets
- bu_valid  in  [1:0]  branch unit k reports a resolved branch
- bu_bs_ptr  in  [1:0][log2 N_BS-1:0]  branch stack tag of the reported branch
- bu_mispred  in  [1:0]  reported branch was mispredicted
- bu_bmask  in  [1:0][N_BS-1:0]  B_MASK of the reported branch (older unresolved branches)
- br_branch_resolved  out  1  resolution issued to the branch stack this cycle
- br_bs_ptr  out  log2 N_BS  tag being resolved
- br_pred_wrong  out  1  issued resolution is a mispredict
- ctrl_recovering  out  1  recovery window active; fetch/dispatch stall
- ctrl_pending  out  N_BS  valid bits of the pending table
- ctrl_err  out  1  sticky; duplicate report for an already-pending tag

## Operation
- Pending slot i holds: valid, mispred, bmask[N_BS-1:0].
- Capture: bu_valid[k] writes slot bu_bs_ptr[k] at the posedge.
  - If both ports report the same tag, port 0 wins.
  - If the slot is already valid, the write is dropped and ctrl_err is set.
- Ordering: a set bmask[j] means j is older. The oldest mispredict is the pending mispredicted slot i for which no other pending mispredicted j has bmask_i[j]=1. If several qualify, the lowest i wins.
- Issue, RUN state only, one per cycle:
  - If any mispredict is pending, issue the oldest one.
  - Otherwise issue the lowest-index pending slot.
  - The issued slot is cleared at the posedge.
- Correct issue of tag t: clear bmask[t] in every pending slot and in any report captured the same cycle.
- Mispredict issue of tag t:
  - Invalidate every pending slot with bmask[t]=1.
  - Drop same-cycle reports with bu_bmask[t]=1.
  - Load squash_mask = bit t.
  - Go to RECOVER with count = RECOVER_CYCLES.
- FSM:
  - RUN → RECOVER on a mispredict issue.
  - RECOVER: count decrements each cycle. RECOVER → RUN when count==1 at the posedge.
  - In RECOVER, no issue occurs (br_branch_resolved=0).
  - In RECOVER, reports are still captured, except those with (bu_bmask & squash_mask)≠0, which are dropped silently.
  - squash_mask clears on return to RUN.
- Reset values: all slots invalid, RUN, count 0, squash_mask 0, ctrl_err 0. All outputs 0.

## Timing
- All outputs are functions of registered state only; there is no combinational path from bu_* to br_*.
- Minimum latency: a report sampled at posedge P drives br_branch_resolved during the cycle after P, and is consumed at posedge P+1.
- br_bs_ptr and br_pred_wrong are 0 when br_branch_resolved=0.
- ctrl_recovering=1 for exactly RECOVER_CYCLES cycles, starting the cycle after br_pred_wrong=1.
- Slot reuse: a tag issued at posedge P may be re-reported in the cycle ending at P+1 without error, because the slot is clear by then.
- Same-cycle issue and capture of the same tag: the capture wins, since the slot was freed in that cycle. ctrl_err is not set.
- Reset asserted mid-recovery aborts recovery. ctrl_recovering is 0 the following cycle.
- No overflow is possible: tags are unique and there are N_BS slots.

## Test plan
- Single correct report (tag 2, bmask 0000) → next cycle: resolved=1, bs_ptr=2, pred_wrong=0; following cycle: resolved=0, ctrl_pending=0000.
- Dual correct reports (tags 1 and 3) in one cycle → resolutions of tag 1 then tag 3 on consecutive cycles; tag 3's bmask bit 1 cleared after the first issue.
- Mispredict ordering: pending correct tag 0 (bmask 0000), mispredict tag 1 (bmask 0001), mispredict tag 2 (bmask 0011) →
  - tag 1 issued first with pred_wrong=1;
  - tag 2 squashed;
  - ctrl_recovering high for 2 cycles;
  - tag 0 issued in the cycle after recovery ends.
- Wrong-path report during RECOVER with bmask bit 1 set → dropped; ctrl_pending unchanged; ctrl_err=0.
- Duplicate report of pending tag 3 → ctrl_err=1 and stays set; the original slot contents are unchanged.
- reset=0 asserted during the second RECOVER cycle → next cycle: all outputs 0; state RUN; subsequent report issues normally.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer: buffers up to two reports per cycle in a tag-indexed
// pending table and issues one per cycle to the branch stack, oldest mispredict first.
module branch_resolve_ctrl #(
    parameter int N_BS           = 4,
    parameter int RECOVER_CYCLES = 2,
    localparam int TW            = (N_BS > 1) ? $clog2(N_BS) : 1,
    localparam int CW            = $clog2(RECOVER_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               bu_valid,
    input  logic [1:0][TW-1:0]       bu_bs_ptr,
    input  logic [1:0]               bu_mispred,
    input  logic [1:0][N_BS-1:0]     bu_bmask,
    output logic                     br_branch_resolved,
    output logic [TW-1:0]            br_bs_ptr,
    output logic                     br_pred_wrong,
    output logic                     ctrl_recovering,
    output logic [N_BS-1:0]          ctrl_pending,
    output logic                     ctrl_err
);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [N_BS-1:0]          squash_q, squash_d;
    logic                     err_q, err_d;
    logic [N_BS-1:0]          valid_q, valid_d;
    logic [N_BS-1:0]          mispred_q, mispred_d;
    logic [N_BS-1:0][N_BS-1:0] bmask_q, bmask_d;

    logic [N_BS-1:0]          mis_pend;
    logic [N_BS-1:0]          oldest;
    logic [N_BS-1:0]          others;
    logic [N_BS-1:0]          cand;
    logic [TW-1:0]            issue_tag;
    logic                     issue_valid;
    logic                     issue_mis;
    logic [N_BS-1:0]          cap_mask;
    logic                     drop;
    logic                     busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            count_q   <= '0;
            squash_q  <= '0;
            err_q     <= 1'b0;
            valid_q   <= '0;
            mispred_q <= '0;
            bmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            squash_q  <= squash_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            mispred_q <= mispred_d;
            bmask_q   <= bmask_d;
        end
    end

    // Selection: a mispredict is oldest when no other pending mispredict is in its bmask.
    always_comb begin
        mis_pend = valid_q & mispred_q;
        oldest   = '0;
        others   = '0;
        for (int i = 0; i < N_BS; i++) begin
            others    = mis_pend;
            others[i] = 1'b0;
            if (mis_pend[i] && ((bmask_q[i] & others) == '0)) begin
                oldest[i] = 1'b1;
            end
        end
        if (|oldest) begin
            cand = oldest;
        end else if (|mis_pend) begin
            cand = mis_pend;
        end else begin
            cand = valid_q;
        end
        issue_tag = '0;
        for (int i = N_BS - 1; i >= 0; i--) begin
            if (cand[i]) begin
                issue_tag = TW'(i);
            end
        end
        issue_valid = (state_q == RUN) && (|valid_q);
        issue_mis   = issue_valid && mispred_q[issue_tag];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        squash_d  = squash_q;
        err_d     = err_q;
        valid_d   = valid_q;
        mispred_d = mispred_q;
        bmask_d   = bmask_q;
        cap_mask  = '0;
        drop      = 1'b0;
        busy      = 1'b0;

        if (issue_valid) begin
            valid_d[issue_tag] = 1'b0;
            if (issue_mis) begin
                for (int i = 0; i < N_BS; i++) begin
                    if (bmask_q[i][issue_tag]) begin
                        valid_d[i] = 1'b0;
                    end
                end
                state_d             = RECOVER;
                count_d             = CW'(RECOVER_CYCLES);
                squash_d            = '0;
                squash_d[issue_tag] = 1'b1;
            end else begin
                for (int i = 0; i < N_BS; i++) begin
                    bmask_d[i][issue_tag] = 1'b0;
                end
            end
        end else if (state_q == RECOVER) begin
            if (count_q == CW'(1)) begin
                state_d  = RUN;
                count_d  = '0;
                squash_d = '0;
            end else begin
                count_d = count_q - CW'(1);
            end
        end

        // A slot being issued this cycle counts as free, so a same-cycle re-report is captured.
        for (int k = 0; k < 2; k++) begin
            cap_mask = bu_bmask[k];
            if (issue_valid && !issue_mis) begin
                cap_mask[issue_tag] = 1'b0;
            end
            drop = ((state_q == RECOVER) && ((bu_bmask[k] & squash_q) != '0))
                || (issue_mis && bu_bmask[k][issue_tag]);
            if (k == 1 && bu_valid[0] && (bu_bs_ptr[0] == bu_bs_ptr[1])) begin
                drop = 1'b1;
            end
            busy = valid_q[bu_bs_ptr[k]] && !(issue_valid && (issue_tag == bu_bs_ptr[k]));
            if (bu_valid[k] && !drop) begin
                if (busy) begin
                    err_d = 1'b1;
                end else begin
                    valid_d[bu_bs_ptr[k]]   = 1'b1;
                    mispred_d[bu_bs_ptr[k]] = bu_mispred[k];
                    bmask_d[bu_bs_ptr[k]]   = cap_mask;
                end
            end
        end
    end

    always_comb begin
        br_branch_resolved = issue_valid;
        br_bs_ptr          = issue_valid ? issue_tag : '0;
        br_pred_wrong      = issue_mis;
        ctrl_recovering    = (state_q == RECOVER);
        ctrl_pending       = valid_q;
        ctrl_err           = err_q;
    end

endmodule
